operand_fetch: RTL and testbench

- Operand-fetch sequencer between instruction decode and the ALU.
- Drives the single-port, combinational-read register file (regnum/rw/datain/dataout).
- Per decoded instruction, reads the source (register or constant bank) and optionally the destination, then presents both operands to the ALU with a valid/ready handshake.
- Arbitrates ALU/load writeback into the same port; writeback has priority over reads.

---
 rtl/operand_fetch.sv | 137 +++++++++++++
 tb/tb_operand_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch sequencer: reads source and optional destination operands through the
// shared register-file port, gives writeback priority, and hands operands to the ALU.
module operand_fetch #(
    parameter int DATA_W     = 16,
    parameter int RNUM_W     = 8,
    parameter int CONST_BASE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_src,
    input  logic              req_rc,
    input  logic [2:0]        req_dst,
    input  logic              req_need_dst,
    input  logic              wb_valid,
    input  logic [3:0]        wb_num,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic [RNUM_W-1:0] rf_regnum,
    output logic              rf_rw,
    output logic [DATA_W-1:0] rf_datain,
    input  logic [DATA_W-1:0] rf_dataout,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_src,
    output logic [DATA_W-1:0] op_dst,
    output logic [2:0]        op_dst_num
);

    typedef enum logic [1:0] {IDLE, RD_SRC, RD_DST, OUT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        src_q, src_d;
    logic [2:0]        dst_q, dst_d;
    logic              rc_q, rc_d;
    logic              need_dst_q, need_dst_d;
    logic [DATA_W-1:0] op_src_q, op_src_d;
    logic [DATA_W-1:0] op_dst_q, op_dst_d;
    logic              op_valid_q, op_valid_d;
    logic              wb_err_q, wb_err_d;
    logic              wb_write;
    logic [RNUM_W-1:0] read_idx;

    // Writes into the constant bank are dropped and never steal the port.
    assign wb_write = wb_valid && !wb_num[3];

    always_comb begin
        read_idx = '0;
        case (state_q)
            RD_SRC:  read_idx = rc_q ? RNUM_W'(CONST_BASE) + RNUM_W'(src_q) : RNUM_W'(src_q);
            RD_DST:  read_idx = RNUM_W'(dst_q);
            default: read_idx = '0;
        endcase
    end

    always_comb begin
        rf_rw     = wb_write;
        rf_regnum = wb_write ? RNUM_W'(wb_num) : read_idx;
        rf_datain = wb_write ? wb_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rc_q       <= 1'b0;
            need_dst_q <= 1'b0;
            op_src_q   <= '0;
            op_dst_q   <= '0;
            op_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rc_q       <= rc_d;
            need_dst_q <= need_dst_d;
            op_src_q   <= op_src_d;
            op_dst_q   <= op_dst_d;
            op_valid_q <= op_valid_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // A real writeback owns the port, so read states simply repeat that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = RD_SRC;
            RD_SRC:  if (!wb_write) state_d = need_dst_q ? RD_DST : OUT;
            RD_DST:  if (!wb_write) state_d = OUT;
            OUT:     if (op_valid_q && op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        rc_d       = rc_q;
        need_dst_d = need_dst_q;
        op_src_d   = op_src_q;
        op_dst_d   = op_dst_q;
        wb_err_d   = wb_valid && wb_num[3];
        op_valid_d = (state_q == OUT) && !(op_valid_q && op_ready);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src_d      = req_src;
                    dst_d      = req_dst;
                    rc_d       = req_rc;
                    need_dst_d = req_need_dst;
                end
            end
            RD_SRC: begin
                if (!wb_write) begin
                    op_src_d = rf_dataout;
                    if (!need_dst_q) op_dst_d = '0;
                end
            end
            RD_DST: begin
                if (!wb_write) op_dst_d = rf_dataout;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign op_valid   = op_valid_q;
    assign op_src     = op_src_q;
    assign op_dst     = op_dst_q;
    assign op_dst_num = dst_q;
    assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: drives directed and random instructions and writebacks against
// a register-file model, predicting operands and latency from a shadow copy of the file.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_src;
    logic        req_rc;
    logic [2:0]  req_dst;
    logic        req_need_dst;
    logic        wb_valid;
    logic [3:0]  wb_num;
    logic [15:0] wb_data;
    logic        wb_err;
    logic [7:0]  rf_regnum;
    logic        rf_rw;
    logic [15:0] rf_datain;
    logic [15:0] rf_dataout;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_src;
    logic [15:0] op_dst;
    logic [2:0]  op_dst_num;

    logic [15:0] mem [256];
    logic [15:0] golden [16];
    logic [15:0] const_vals [8];
    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_rc(req_rc), .req_dst(req_dst), .req_need_dst(req_need_dst),
        .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data), .wb_err(wb_err),
        .rf_regnum(rf_regnum), .rf_rw(rf_rw), .rf_datain(rf_datain), .rf_dataout(rf_dataout),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_src(op_src), .op_dst(op_dst), .op_dst_num(op_dst_num)
    );

    always #5 clk = ~clk;

    assign rf_dataout = mem[rf_regnum];
    always @(posedge clk) begin
        if (rf_rw) mem[rf_regnum] <= rf_datain;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyWriteback(input logic [3:0] num, input logic [15:0] data);
        wb_valid = 1'b1;
        wb_num   = num;
        wb_data  = data;
        #1;
        checkOutput("wb_rw", 32'(rf_rw), 32'(!num[3]));
        if (!num[3]) begin
            checkOutput("wb_regnum", 32'(rf_regnum), 32'(num));
            checkOutput("wb_datain", 32'(rf_datain), 32'(data));
            golden[num] = data;
        end
        tick;
        wb_valid = 1'b0;
        checkOutput("wb_err_pulse", 32'(wb_err), 32'(num[3]));
    endtask

    task automatic applyStimulus(input logic [2:0] src, input logic rc, input logic [2:0] dst,
                                 input logic need, input logic inject, input logic [3:0] wnum,
                                 input logic [15:0] wdata, input int hold, input logic early);
        int          cyc;
        logic [3:0]  sidx;
        logic [3:0]  hnum;
        logic [15:0] hdata;
        logic [15:0] es;
        logic [15:0] ed;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_src      = src;
        req_rc       = rc;
        req_dst      = dst;
        req_need_dst = need;
        tick;
        req_valid    = 1'b0;
        req_src      = 3'($urandom);
        req_rc       = 1'($urandom);
        req_dst      = 3'($urandom);
        req_need_dst = 1'($urandom);
        op_ready     = early;
        cyc = 0;
        if (inject) begin
            wb_valid = 1'b1;
            wb_num   = wnum;
            wb_data  = wdata;
            #1;
            checkOutput("inject_rw", 32'(rf_rw), 32'(!wnum[3]));
            if (!wnum[3]) golden[wnum] = wdata;
            tick;
            wb_valid = 1'b0;
            cyc = 1;
            checkOutput("inject_err", 32'(wb_err), 32'(wnum[3]));
        end
        sidx = rc ? 4'(8 + 32'(src)) : {1'b0, src};
        es   = golden[sidx];
        ed   = need ? golden[{1'b0, dst}] : 16'h0000;
        while (!op_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(2 + 32'(need) + 32'(inject && !wnum[3])));
        checkOutput("op_src", 32'(op_src), 32'(es));
        checkOutput("op_dst", 32'(op_dst), 32'(ed));
        checkOutput("op_dst_num", 32'(op_dst_num), 32'(dst));
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        if (!early) begin
            op_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                hnum  = 4'($urandom);
                hdata = 16'($urandom);
                wb_valid = 1'b1;
                wb_num   = hnum;
                wb_data  = hdata;
                #1;
                checkOutput("hold_rw", 32'(rf_rw), 32'(!hnum[3]));
                if (!hnum[3]) golden[hnum] = hdata;
                tick;
                wb_valid = 1'b0;
                checkOutput("hold_valid", 32'(op_valid), 32'd1);
                checkOutput("hold_src", 32'(op_src), 32'(es));
                checkOutput("hold_dst", 32'(op_dst), 32'(ed));
                checkOutput("hold_ready", 32'(req_ready), 32'd0);
            end
            op_ready = 1'b1;
        end
        tick;
        op_ready = 1'b0;
        checkOutput("op_valid_drop", 32'(op_valid), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        const_vals[0] = 16'h0001; const_vals[1] = 16'h0002;
        const_vals[2] = 16'h0004; const_vals[3] = 16'h0008;
        const_vals[4] = 16'h00FF; const_vals[5] = 16'h7FFF;
        const_vals[6] = 16'h8000; const_vals[7] = 16'hFFFF;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) golden[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            mem[8 + i]    = const_vals[i];
            golden[8 + i] = const_vals[i];
        end
        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_src = '0; req_rc = 1'b0; req_dst = '0; req_need_dst = 1'b0;
        wb_valid = 1'b0; wb_num = '0; wb_data = '0; op_ready = 1'b0;
        tick;
        tick;
        checkOutput("rst_op_valid", 32'(op_valid), 32'd0);
        checkOutput("rst_op_src", 32'(op_src), 32'd0);
        checkOutput("rst_op_dst", 32'(op_dst), 32'd0);
        checkOutput("rst_op_dst_num", 32'(op_dst_num), 32'd0);
        checkOutput("rst_wb_err", 32'(wb_err), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rf_rw", 32'(rf_rw), 32'd0);
        checkOutput("rst_rf_regnum", 32'(rf_regnum), 32'd0);
        checkOutput("rst_rf_datain", 32'(rf_datain), 32'd0);
        rst_n = 1'b1;
        tick;

        $display("[TB] directed: two-operand read");
        applyWriteback(4'd2, 16'h1234);
        applyWriteback(4'd5, 16'h00FF);
        req_valid = 1'b1; req_src = 3'd2; req_rc = 1'b0; req_dst = 3'd5; req_need_dst = 1'b1;
        tick;
        req_valid = 1'b0;
        checkOutput("t1_regnum_src", 32'(rf_regnum), 32'd2);
        tick;
        checkOutput("t1_regnum_dst", 32'(rf_regnum), 32'd5);
        checkOutput("t1_valid_e1", 32'(op_valid), 32'd0);
        tick;
        checkOutput("t1_valid_e2", 32'(op_valid), 32'd0);
        tick;
        checkOutput("t1_valid_e3", 32'(op_valid), 32'd1);
        checkOutput("t1_op_src", 32'(op_src), 32'h1234);
        checkOutput("t1_op_dst", 32'(op_dst), 32'h00FF);
        checkOutput("t1_dst_num", 32'(op_dst_num), 32'd5);
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        checkOutput("t1_valid_drop", 32'(op_valid), 32'd0);
        checkOutput("t1_req_ready", 32'(req_ready), 32'd1);

        $display("[TB] directed: constant source");
        req_valid = 1'b1; req_src = 3'd7; req_rc = 1'b1; req_dst = 3'd4; req_need_dst = 1'b0;
        tick;
        req_valid = 1'b0;
        checkOutput("t2_regnum", 32'(rf_regnum), 32'd15);
        tick;
        tick;
        checkOutput("t2_valid_e2", 32'(op_valid), 32'd1);
        checkOutput("t2_op_src", 32'(op_src), 32'hFFFF);
        checkOutput("t2_op_dst", 32'(op_dst), 32'd0);
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;

        $display("[TB] directed: writeback collides with source read");
        applyWriteback(4'd3, 16'h1111);
        applyStimulus(3'd3, 1'b0, 3'd1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 0, 1'b0);

        $display("[TB] directed: dropped constant writeback");
        applyWriteback(4'd9, 16'hAAAA);
        tick;
        checkOutput("t4_err_clear", 32'(wb_err), 32'd0);
        applyStimulus(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0, 16'h0, 0, 1'b0);
        checkOutput("t4_const_kept", 32'(op_src), 32'(const_vals[1]));

        $display("[TB] directed: ALU back-pressure");
        applyStimulus(3'd2, 1'b0, 3'd5, 1'b1, 1'b0, 4'd0, 16'h0, 4, 1'b0);

        $display("[TB] directed: reset during destination read");
        req_valid = 1'b1; req_src = 3'd2; req_rc = 1'b0; req_dst = 3'd5; req_need_dst = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        checkOutput("t6_pre_src", 32'(op_src), 32'(golden[2]));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_op_valid", 32'(op_valid), 32'd0);
        checkOutput("t6_op_src", 32'(op_src), 32'd0);
        checkOutput("t6_op_dst_num", 32'(op_dst_num), 32'd0);
        checkOutput("t6_req_ready", 32'(req_ready), 32'd1);
        checkOutput("t6_regnum", 32'(rf_regnum), 32'd0);
        tick;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput("t6_no_valid", 32'(op_valid), 32'd0);
            checkOutput("t6_idle", 32'(req_ready), 32'd1);
        end

        $display("[TB] random instructions");
        for (int i = 0; i < 8; i++) applyWriteback(4'(i), 16'($urandom));
        for (int n = 0; n < 40; n++) begin
            applyStimulus(3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                          ($urandom_range(0, 1) == 1), 4'($urandom), 16'($urandom),
                          $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) applyWriteback(4'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
